key_debounce_reset: RTL and testbench

//  Debounces the raw board push-buttons (active-low) into clean level and edge signals.

---
 rtl/key_debounce_reset.sv | 175 +++++++++++++++++
 tb/tb_key_debounce_reset.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_reset.sv
// Push-button debouncer and stretched system reset generator (key 0 = reset key).
// Optional per-key long-press pulse: define KEY_DEBOUNCE_RESET_LONG_PRESS_EN.
module key_debounce_reset #(
  parameter int NUM_KEYS          = 2,
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int RST_HOLD_CYCLES   = 1024,
  parameter int LONG_PRESS_CYCLES = 200_000_000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                sys_resetn,
  output logic [NUM_KEYS-1:0] long_press
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    RST_ASSERT,
    RST_HOLD,
    RST_RUN
  } rst_state_e;

  logic [NUM_KEYS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_KEYS-1:0] pressed_s;
  logic [DW-1:0]       db_cnt [NUM_KEYS];
  logic [DW-1:0]       db_cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] level_d;
  logic [NUM_KEYS-1:0] press_d;
  logic [NUM_KEYS-1:0] release_d;

  rst_state_e          state;
  rst_state_e          state_d;
  logic [HW-1:0]       hold_cnt;
  logic [HW-1:0]       hold_d;
  logic                sys_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '1;
      end
    end else begin
      sync_q[0] <= key_n;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign pressed_s = ~sync_q[SYNC_STAGES-1];

  // A change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_comb begin
    level_d   = key_level;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      db_cnt_d[i] = '0;
      if (pressed_s[i] != key_level[i]) begin
        if (db_cnt[i] == DB_LAST) begin
          level_d[i]   = pressed_s[i];
          press_d[i]   = pressed_s[i];
          release_d[i] = ~pressed_s[i];
        end else begin
          db_cnt_d[i] = db_cnt[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        db_cnt[i] <= '0;
      end
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        db_cnt[i] <= db_cnt_d[i];
      end
      key_level   <= level_d;
      key_press   <= press_d;
      key_release <= release_d;
    end
  end

  // The FSM watches key 0's level as it is registered, so sys_resetn
  // drops together with key_press[0] and the hold starts with key_release[0].
  always_comb begin
    state_d = state;
    hold_d  = hold_cnt;
    unique case (state)
      RST_ASSERT: begin
        hold_d = '0;
        if (resetn && !level_d[0]) begin
          state_d = RST_HOLD;
        end
      end
      RST_HOLD: begin
        if (level_d[0]) begin
          state_d = RST_ASSERT;
          hold_d  = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_d = RST_RUN;
          hold_d  = '0;
        end else begin
          hold_d = hold_cnt + HW'(1);
        end
      end
      RST_RUN: begin
        hold_d = '0;
        if (level_d[0]) begin
          state_d = RST_ASSERT;
        end
      end
      default: begin
        state_d = RST_ASSERT;
        hold_d  = '0;
      end
    endcase
    sys_d = (state == RST_RUN) && !level_d[0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= RST_ASSERT;
      hold_cnt   <= '0;
      sys_resetn <= 1'b0;
    end else begin
      state      <= state_d;
      hold_cnt   <= hold_d;
      sys_resetn <= sys_d;
    end
  end

`ifdef KEY_DEBOUNCE_RESET_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [LW-1:0] LP_MAX = LW'(LONG_PRESS_CYCLES);
  localparam logic [LW-1:0] LP_LAST = LW'(LONG_PRESS_CYCLES - 1);

  logic [LW-1:0] held_cnt [NUM_KEYS];

  // Saturating at LP_MAX makes the LP_LAST match happen once per press
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        held_cnt[i] <= '0;
      end
      long_press <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        long_press[i] <= key_level[i] && (held_cnt[i] == LP_LAST);
        if (!key_level[i]) begin
          held_cnt[i] <= '0;
        end else if (held_cnt[i] != LP_MAX) begin
          held_cnt[i] <= held_cnt[i] + LW'(1);
        end
      end
    end
  end
`else
  assign long_press = '0;
`endif

endmodule

// File: tb/tb_key_debounce_reset.sv
// Randomized and directed bench for key_debounce_reset against a
// window/streak reference model of the debounce and reset rules.
module tb_key_debounce_reset;

  localparam int NK  = 2;
  localparam int SS  = 2;
  localparam int DC  = 8;
  localparam int RH  = 4;
  localparam int LPC = 20;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic          sys_resetn;
  logic [NK-1:0] long_press;

  int errors = 0;
  int checks = 0;

  key_debounce_reset #(
    .NUM_KEYS(NK),
    .SYNC_STAGES(SS),
    .DEBOUNCE_CYCLES(DC),
    .RST_HOLD_CYCLES(RH),
    .LONG_PRESS_CYCLES(LPC)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .key_n(key_n),
    .key_level(key_level),
    .key_press(key_press),
    .key_release(key_release),
    .sys_resetn(sys_resetn),
    .long_press(long_press)
  );

  always #5 clk = ~clk;

  // reference model
  logic [NK-1:0] pipe_q [$];
  logic [NK-1:0] win_q [$];
  logic [NK-1:0] m_level = '0;
  logic [NK-1:0] m_press = '0;
  logic [NK-1:0] m_release = '0;
  logic [NK-1:0] m_long = '0;
  logic          m_sys = 1'b0;
  int            quiet = 0;
  int            held [NK];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [NK-1:0] eff;
    logic [NK-1:0] prev;
    logic [NK-1:0] flip;
    prev = m_level;
    if (!resetn) begin
      pipe_q.delete();
      repeat (SS) pipe_q.push_back('1);
      win_q.delete();
      m_level = '0;
      m_press = '0;
      m_release = '0;
      m_long = '0;
      m_sys = 1'b0;
      quiet = 0;
      for (int k = 0; k < NK; k++) held[k] = 0;
    end else begin
      eff = ~pipe_q.pop_front();
      pipe_q.push_back(key_n);
      win_q.push_back(eff);
      if (win_q.size() > DC) void'(win_q.pop_front());
      for (int k = 0; k < NK; k++) begin
        flip[k] = (win_q.size() == DC);
        foreach (win_q[j]) if (win_q[j][k] == m_level[k]) flip[k] = 1'b0;
      end
      m_level = m_level ^ flip;
      m_press = flip & m_level;
      m_release = flip & ~m_level;
      m_long = '0;
      for (int k = 0; k < NK; k++) begin
        held[k] = prev[k] ? held[k] + 1 : 0;
`ifdef KEY_DEBOUNCE_RESET_LONG_PRESS_EN
        m_long[k] = (held[k] == LPC);
`endif
      end
      quiet = m_level[0] ? 0 : quiet + 1;
      m_sys = (quiet >= RH + 2);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("level", 32'(key_level), 32'(m_level));
    check("press", 32'(key_press), 32'(m_press));
    check("release", 32'(key_release), 32'(m_release));
    check("sys_resetn", 32'(sys_resetn), 32'(m_sys));
    check("long_press", 32'(long_press), 32'(m_long));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // which: 0 press, 1 release, 2 sys rise, 3 sys fall, 4 long_press
  task automatic lat_to(input int which, input int k, output int lat);
    logic hit;
    lat = -1;
    for (int i = 1; i <= 64; i++) begin
      step();
      unique case (which)
        0: hit = key_press[k];
        1: hit = key_release[k];
        2: hit = sys_resetn;
        3: hit = !sys_resetn;
        default: hit = long_press[k];
      endcase
      if (hit) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int cnt;
    int runlen [NK];

    // reset then release with keys idle
    resetn = 1'b0;
    run(3);
    check("rst_sys", 32'(sys_resetn), 32'd0);
    check("rst_level", 32'(key_level), 32'd0);
    resetn = 1'b1;
    step();
    lat_to(2, 0, lat);
    check("rst_release_lat", lat, RH + 1);
    run(4);

    // clean press / release on key 1
    key_n[1] = 1'b0;
    lat_to(0, 1, lat);
    check("press1_lat", lat, SS + DC);
    run(15);
    key_n[1] = 1'b1;
    lat_to(1, 1, lat);
    check("release1_lat", lat, SS + DC);
    run(5);

    // bouncing key 1: runs of 5 low never accepted
    cnt = 0;
    repeat (8) begin
      key_n[1] = 1'b0;
      repeat (5) begin step(); cnt += int'(key_press[1]); end
      key_n[1] = 1'b1;
      repeat (2) begin step(); cnt += int'(key_press[1]); end
    end
    check("bounce_no_press", cnt, 0);
    key_n[1] = 1'b0;
    lat_to(0, 1, lat);
    check("bounce_final_lat", lat, SS + DC);
    run(3);
    key_n[1] = 1'b1;
    run(20);

    // key 0 as a reset button while running
    check("run_sys", 32'(sys_resetn), 32'd1);
    key_n[0] = 1'b0;
    lat_to(0, 0, lat);
    check("press0_lat", lat, SS + DC);
    check("sys_at_press0", 32'(sys_resetn), 32'd0);
    run(20);
    key_n[0] = 1'b1;
    lat_to(1, 0, lat);
    check("release0_lat", lat, SS + DC);
    lat_to(2, 0, lat);
    check("sys_after_release0", lat, RH + 1);

    // key 0 pin pressed again right after its release pulse
    key_n[0] = 1'b0;
    run(12);
    key_n[0] = 1'b1;
    run(16);
    key_n[0] = 1'b0;
    run(14);
    key_n[0] = 1'b1;
    lat_to(1, 0, lat);
    check("rerelease0_lat", lat, SS + DC);
    lat_to(2, 0, lat);
    check("sys_after_rerelease0", lat, RH + 1);

    // mid-operation reset with key 1 held
    key_n[1] = 1'b0;
    run(14);
    resetn = 1'b0;
    step();
    check("midrst_level", 32'(key_level), 32'd0);
    check("midrst_sys", 32'(sys_resetn), 32'd0);
    resetn = 1'b1;
    key_n[1] = 1'b1;
    run(20);

    // long hold on key 1
    key_n[1] = 1'b0;
    lat_to(0, 1, lat);
    cnt = 0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (long_press[1]) begin
        cnt++;
        if (lat < 0) lat = i;
      end
    end
`ifdef KEY_DEBOUNCE_RESET_LONG_PRESS_EN
    check("long_count", cnt, 1);
    check("long_lat", lat, LPC);
`else
    check("long_count", cnt, 0);
`endif
    key_n[1] = 1'b1;
    run(20);

    // random bouncing with occasional reset
    for (int k = 0; k < NK; k++) runlen[k] = 1;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < NK; k++) begin
        runlen[k]--;
        if (runlen[k] == 0) begin
          key_n[k] = ~key_n[k];
          runlen[k] = int'($urandom_range(14, 1));
        end
      end
      resetn = ($urandom_range(299, 0) != 0);
      step();
    end
    resetn = 1'b1;
    key_n = '1;
    run(30);
    check("final_sys", 32'(sys_resetn), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
